// File: rtl/hf14a_reader_seq.sv
// hf14a_reader_seq: ISO14443-A reader frame sequencer, Modified Miller pause timing plus listen-window supervision; define HF14A_CRC_EN to append CRC_A
module hf14a_reader_seq #(
  parameter int PAUSE_LEN    = 32,
  parameter int IDLE_STROBES = 16,
  parameter int TIMEOUT_CYC  = 8192
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  input  logic       tx_short,
  output logic       tx_ready,
  input  logic       rx_strobe,
  input  logic       rx_bit,
  output logic       mod_pause,
  output logic [2:0] mod_type,
  output logic       busy,
  output logic       done,
  output logic       rx_ok,
  output logic       timeout,
  output logic       tx_underrun
);
  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_DATA, S_PAR,
`ifdef HF14A_CRC_EN
    S_CRC,
`endif
    S_EOF0, S_EOF1, S_LISTEN
  } state_t;

  localparam logic [7:0]  Z_END    = 8'(PAUSE_LEN);
  localparam logic [7:0]  X_END    = 8'(64 + PAUSE_LEN);
  localparam logic [7:0]  ZC_LAST  = 8'(IDLE_STROBES - 1);
  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [6:0]  bc_q, bc_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        hold_last_q, hold_last_d;
  logic        hold_short_q, hold_short_d;
  logic        lock_q, lock_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d;
  logic        last_q, last_d;
  logic        frm_short_q, frm_short_d;
  logic        prev_q, prev_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  zc_q, zc_d;
  logic        seen_q, seen_d;
`ifdef HF14A_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        in_crc_q, in_crc_d;
  logic        crc_hi_q, crc_hi_d;
`endif
  logic        acc, load, shifting, cur, tx_act, x_win, z_win;

`ifdef HF14A_CRC_EN
  assign shifting = state_q == S_DATA || state_q == S_CRC;
`else
  assign shifting = state_q == S_DATA;
`endif
  assign acc      = tx_valid && tx_ready;
  assign tx_ready = !hold_full_q && !lock_q;
  assign busy     = state_q != S_IDLE;
  assign mod_type = state_q == S_LISTEN ? 3'b011 : 3'b100;
  assign done     = rx_ok || timeout;
  assign cur      = state_q == S_PAR ? par_q : shifting ? sh_q[0] : 1'b0;
  assign tx_act   = busy && state_q != S_EOF1 && state_q != S_LISTEN;
  assign x_win    = {1'b0, bc_q} >= 8'd64 && {1'b0, bc_q} < X_END;
  assign z_win    = {1'b0, bc_q} < Z_END;
  assign mod_pause = tx_act && (cur ? x_win : (!prev_q && z_win));

  // State, bit timing, byte path and listen bookkeeping registers
  always_ff @(negedge ck_1356meg or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bc_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_short_q <= 1'b0;
      lock_q       <= 1'b0;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      last_q       <= 1'b0;
      frm_short_q  <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      zc_q         <= '0;
      seen_q       <= 1'b0;
`ifdef HF14A_CRC_EN
      crc_q        <= 16'h6363;
      in_crc_q     <= 1'b0;
      crc_hi_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      hold_last_q  <= hold_last_d;
      hold_short_q <= hold_short_d;
      lock_q       <= lock_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      last_q       <= last_d;
      frm_short_q  <= frm_short_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      zc_q         <= zc_d;
      seen_q       <= seen_d;
`ifdef HF14A_CRC_EN
      crc_q        <= crc_d;
      in_crc_q     <= in_crc_d;
      crc_hi_q     <= crc_hi_d;
`endif
    end
  end

  // Next state: byte intake, per-bit sequencing at period end, listen window outcome
  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    hold_last_d  = hold_last_q;
    hold_short_d = hold_short_q;
    lock_d       = lock_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    last_d       = last_q;
    frm_short_d  = frm_short_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    zc_d         = zc_q;
    seen_d       = seen_q;
`ifdef HF14A_CRC_EN
    crc_d        = crc_q;
    in_crc_d     = in_crc_q;
    crc_hi_d     = crc_hi_q;
`endif
    load         = 1'b0;
    rx_ok        = 1'b0;
    timeout      = 1'b0;
    tx_underrun  = 1'b0;
    if (acc) begin
      hold_d       = tx_data;
      hold_full_d  = 1'b1;
      hold_last_d  = tx_last;
      hold_short_d = tx_last && tx_short;
      lock_d       = tx_last;
    end
    case (state_q)
      S_IDLE: if (acc) begin
        state_d = S_SOF;
        bc_d    = '0;
        prev_d  = 1'b0;
`ifdef HF14A_CRC_EN
        crc_d    = 16'h6363;
        in_crc_d = 1'b0;
        crc_hi_d = 1'b0;
`endif
      end
      S_LISTEN: begin
        cnt_d = cnt_q + 20'd1;
        if (rx_strobe) begin
          seen_d = seen_q || rx_bit;
          zc_d   = rx_bit ? 8'd0 : zc_q + 8'd1;
        end
        rx_ok   = seen_q && rx_strobe && !rx_bit && zc_q == ZC_LAST;
        timeout = !seen_q && cnt_q == CNT_LAST;
        if (rx_ok || timeout) begin
          state_d = S_IDLE;
          lock_d  = 1'b0;
        end
      end
      default: begin
        bc_d = bc_q + 7'd1;
        if (bc_q == 7'd127) begin
          prev_d = cur;
          case (state_q)
            S_SOF: begin
              load    = 1'b1;
              state_d = S_DATA;
            end
            S_PAR: begin
`ifdef HF14A_CRC_EN
              if (in_crc_q && crc_hi_q) state_d = S_EOF0;
              else if (in_crc_q || last_q) begin
                sh_d      = in_crc_q ? crc_q[15:8] : crc_q[7:0];
                par_d     = ~^sh_d;
                bit_cnt_d = '0;
                crc_hi_d  = in_crc_q;
                in_crc_d  = 1'b1;
                state_d   = S_CRC;
              end else
`else
              if (last_q) state_d = S_EOF0;
              else
`endif
              if (hold_full_q) begin
                load    = 1'b1;
                state_d = S_DATA;
              end else begin
                tx_underrun = 1'b1;
                lock_d      = 1'b1;
                state_d     = S_EOF0;
              end
            end
            S_EOF0: state_d = S_EOF1;
            S_EOF1: begin
              state_d = S_LISTEN;
              cnt_d   = '0;
              zc_d    = '0;
              seen_d  = 1'b0;
            end
            default: begin
`ifdef HF14A_CRC_EN
              if (state_q == S_DATA) crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ sh_q[0]) ? 16'h8408 : 16'h0000);
`endif
              if (bit_cnt_q == (frm_short_q ? 3'd6 : 3'd7)) state_d = frm_short_q ? S_EOF0 : S_PAR;
              else begin
                sh_d      = sh_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
          endcase
        end
      end
    endcase
    if (load) begin
      sh_d        = hold_q;
      par_d       = ~^hold_q;
      bit_cnt_d   = '0;
      last_d      = hold_last_q;
      frm_short_d = hold_short_q;
      hold_full_d = 1'b0;
    end
  end
endmodule

// File: tb/tb_hf14a_reader_seq.sv
// tb_hf14a_reader_seq: directed checks of Miller encoding, listen window, underrun and async reset
module tb_hf14a_reader_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0, tx_last = 1'b0, tx_short = 1'b0;
  logic       rx_strobe = 1'b0, rx_bit = 1'b0;
  logic       tx_ready, mod_pause, busy, done, rx_ok, timeout, tx_underrun;
  logic [2:0] mod_type;
  int         checks = 0, errors = 0;
  string      seq;
  int         pauses, up_per, up_bc, n_up, acc_per, k, early;

  always #5 clk = ~clk;

  hf14a_reader_seq dut (
    .ck_1356meg(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_short(tx_short), .tx_ready(tx_ready), .rx_strobe(rx_strobe), .rx_bit(rx_bit),
    .mod_pause(mod_pause), .mod_type(mod_type), .busy(busy), .done(done), .rx_ok(rx_ok),
    .timeout(timeout), .tx_underrun(tx_underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_seq(input string tag, input string exp);
    for (int i = 0; i < exp.len(); i++) check($sformatf("%s_p%0d", tag, i), 32'(seq[i]), 32'(exp[i]));
  endtask

  task automatic send_first(input logic [7:0] d, input logic l, input logic s);
    tx_data = d; tx_last = l; tx_short = s; tx_valid = 1'b1;
    @(posedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic run_frame(input int n);
    seq = ""; pauses = 0; up_per = -1; up_bc = -1; n_up = 0; acc_per = -1;
    for (int p = 0; p < n; p++) begin
      int cnt, first;
      logic acc;
      string c;
      cnt = 0; first = -1;
      for (int b = 0; b < 128; b++) begin
        acc = tx_valid && tx_ready;
        if (mod_pause) begin
          if (first < 0) first = b;
          cnt++;
        end
        if (tx_underrun) begin
          n_up++; up_per = p; up_bc = b;
        end
        if (acc) acc_per = p;
        @(posedge clk);
        if (acc) tx_valid = 1'b0;
      end
      pauses += cnt;
      if (cnt == 0) c = "Y";
      else if (cnt == 32 && first == 0) c = "Z";
      else if (cnt == 32 && first == 64) c = "X";
      else c = "?";
      seq = {seq, c};
    end
  endtask

  task automatic wait_done();
    k = 0;
    while (done !== 1'b1 && k < 9000) begin
      @(posedge clk);
      k++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    check("rst_pause", mod_pause, 0);
    check("rst_type", mod_type, 3'b100);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rxok", rx_ok, 0);
    check("rst_timeout", timeout, 0);
    check("rst_underrun", tx_underrun, 0);
    rst = 1'b0;
    @(posedge clk);

    send_first(8'h26, 1'b1, 1'b1);
    check("reqa_ready_low", tx_ready, 0);
    run_frame(10);
    cmp_seq("reqa", "ZZXXYZXYZY");
    check("reqa_pauses", pauses, 224);
    check("reqa_listen_type", mod_type, 3'b011);
    check("reqa_listen_pause", mod_pause, 0);
    check("reqa_listen_busy", busy, 1);
    wait_done();
    check("to_cycle", k, 8191);
    check("to_timeout", timeout, 1);
    check("to_rxok", rx_ok, 0);
    @(posedge clk);
    check("to_idle_busy", busy, 0);
    check("to_idle_type", mod_type, 3'b100);
    check("to_idle_ready", tx_ready, 1);

`ifdef HF14A_CRC_EN
    send_first(8'h50, 1'b0, 1'b0);
    tx_data = 8'h00; tx_last = 1'b1; tx_valid = 1'b1;
    run_frame(39);
    cmp_seq("crc", "ZZZZZXYXYXYZZZZZZZXXXXYXYXYZXYXXYZXXYZY");
`else
    send_first(8'h93, 1'b0, 1'b0);
    tx_data = 8'h20; tx_last = 1'b1; tx_valid = 1'b1;
    run_frame(21);
    cmp_seq("two", "ZXXYZXYZXXYZZZZXYZZZY");
`endif
    tx_valid = 1'b0;
    check("two_accept_period", acc_per, 1);
    check("two_listen_type", mod_type, 3'b011);
    check("two_listen_ready", tx_ready, 0);

    early = 0;
    for (int s = 0; s < 19; s++) begin
      repeat (15) @(posedge clk);
      rx_strobe = 1'b1; rx_bit = (s < 3);
      #1;
      if (s == 18) begin
        check("rx_done", done, 1);
        check("rx_ok", rx_ok, 1);
        check("rx_no_timeout", timeout, 0);
      end else if (done) early++;
      @(posedge clk);
      rx_strobe = 1'b0; rx_bit = 1'b0;
    end
    check("rx_no_early_done", early, 0);
    check("rx_idle_busy", busy, 0);

    tx_last = 1'b0; tx_short = 1'b0;
    send_first(8'h50, 1'b0, 1'b0);
    run_frame(12);
    cmp_seq("ur", "ZZZZZXYXYXYY");
    check("ur_count", n_up, 1);
    check("ur_period", up_per, 9);
    check("ur_bc", up_bc, 127);
    check("ur_listen_type", mod_type, 3'b011);

    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    send_first(8'h00, 1'b1, 1'b0);
    run_frame(1);
    repeat (10) @(posedge clk);
    check("mid_pause_pre", mod_pause, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_pause", mod_pause, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_type", mod_type, 3'b100);
    check("mid_rst_ready", tx_ready, 1);
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
